// File: rtl/multi_channel_average_pkg.sv
// Shared definitions for the multi-channel averager.
//   MODE_BLOCK / MODE_MOVING : values of the MODE parameter
//   acc_width()              : per-channel accumulator width (sample width + log2 window)
package multi_channel_average_pkg;

    localparam int MODE_BLOCK  = 0;
    localparam int MODE_MOVING = 1;

    // Summing 2^ave_w samples of data_w bits never needs more than ave_w extra bits.
    function automatic int acc_width(input int data_w, input int ave_w);
        return data_w + ave_w;
    endfunction

endpackage

// File: rtl/multi_channel_average_ave_channel.sv
// One averaging channel: accumulator, count/pointer, optional sample ring
// (moving mode only) and the rounding/shift output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart (result register holds)
//   sample, en : input sample and its strobe
//   result     : latest average, held between updates
//   valid      : one-cycle pulse when result updates
module ave_channel
    import multi_channel_average_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AVE_W  = 3,
    parameter int MODE   = MODE_BLOCK,
    parameter int SIGNED = 0,
    parameter int ROUND  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] sample,
    input  logic              en,
    output logic [DATA_W-1:0] result,
    output logic              valid
);

    localparam int N     = 1 << AVE_W;
    localparam int ACC_W = acc_width(DATA_W, AVE_W);
    localparam logic [ACC_W-1:0] RND_C = (ROUND != 0) ? (ACC_W'(1) << (AVE_W - 1)) : '0;

    logic [ACC_W-1:0]  acc, acc_add, sum_q, rnd;
    logic [ACC_W-1:0]  sample_x, oldest_x;
    logic [DATA_W-1:0] oldest;
    logic [AVE_W-1:0]  ptr;
    logic              full, last, fire, fire_q;

    assign sample_x = (SIGNED != 0) ? {{AVE_W{sample[DATA_W-1]}}, sample} : {{AVE_W{1'b0}}, sample};
    assign oldest_x = (SIGNED != 0) ? {{AVE_W{oldest[DATA_W-1]}}, oldest} : {{AVE_W{1'b0}}, oldest};
    assign last     = (ptr == AVE_W'(N - 1));

    // Block mode: ptr counts samples in the window. Moving mode: ptr is the
    // ring write pointer; while filling it doubles as the fill count.
    always_comb begin
        acc_add = acc + sample_x;
        if (MODE == MODE_MOVING && full)
            acc_add = acc + sample_x - oldest_x;
        fire = en && (last || (MODE == MODE_MOVING && full));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            ptr    <= '0;
            full   <= 1'b0;
            sum_q  <= '0;
            fire_q <= 1'b0;
        end else if (clr) begin
            acc    <= '0;
            ptr    <= '0;
            full   <= 1'b0;
            sum_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire;
            if (en) begin
                ptr   <= ptr + 1'b1;
                sum_q <= acc_add;
                // The completing sample is folded into sum_q, so acc restarts clean.
                acc   <= (MODE == MODE_BLOCK && last) ? '0 : acc_add;
                if (MODE == MODE_MOVING && last)
                    full <= 1'b1;
            end
        end
    end

    generate
        if (MODE == MODE_MOVING) begin : g_buf
            logic [DATA_W-1:0] mem [N];
            // No reset needed: a slot is only read after full is set, i.e. after it was written.
            always_ff @(posedge clk) begin
                if (en && !clr)
                    mem[ptr] <= sample;
            end
            assign oldest = mem[ptr];
        end else begin : g_nobuf
            assign oldest = '0;
        end
    endgenerate

    // Rounding add cannot carry out of ACC_W. After truncation to DATA_W the
    // result bits are identical for logical and arithmetic shift.
    assign rnd = sum_q + RND_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            valid  <= 1'b0;
        end else if (clr) begin
            valid  <= 1'b0;
        end else begin
            valid <= fire_q;
            if (fire_q)
                result <= DATA_W'(rnd >> AVE_W);
        end
    end

endmodule

// File: rtl/multi_channel_average.sv
// Multi-channel averager top: CH_NUM independent ave_channel instances plus
// flattening of the sample and result buses.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart of all channels
//   data_in    : flattened samples, channel k at [k*DATA_W +: DATA_W]
//   data_en    : per-channel sample strobes
//   data_out   : flattened averages, held between updates
//   out_valid  : per-channel one-cycle update pulses
module multi_channel_average
    import multi_channel_average_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 32,
    parameter int AVE_W  = 3,
    parameter int MODE   = MODE_BLOCK,
    parameter int SIGNED = 0,
    parameter int ROUND  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [CH_NUM*DATA_W-1:0] data_in,
    input  logic [CH_NUM-1:0]        data_en,
    output logic [CH_NUM*DATA_W-1:0] data_out,
    output logic [CH_NUM-1:0]        out_valid
);

    logic [CH_NUM-1:0][DATA_W-1:0] ch_out;
    logic [CH_NUM-1:0]             ch_vld;

    generate
        for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
            ave_channel #(
                .DATA_W (DATA_W),
                .AVE_W  (AVE_W),
                .MODE   (MODE),
                .SIGNED (SIGNED),
                .ROUND  (ROUND)
            ) u_ch (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr),
                .sample (data_in[k*DATA_W +: DATA_W]),
                .en     (data_en[k]),
                .result (ch_out[k]),
                .valid  (ch_vld[k])
            );
        end
    endgenerate

    assign data_out  = ch_out;
    assign out_valid = ch_vld;

endmodule

// File: tb/tb_multi_channel_average.sv
// Directed bench: three averager instances (block/unsigned/round,
// block/signed/truncate, moving/unsigned/round with N=4).
module tb_multi_channel_average;

    logic         clk, rst_n, clr;
    logic [127:0] din_b, din_s, din_m;
    logic [3:0]   en_b, en_s, en_m;
    logic [127:0] out_b, out_s, out_m;
    logic [3:0]   vld_b, vld_s, vld_m;

    int tests = 0;
    int fails = 0;

    multi_channel_average #(.CH_NUM(4), .DATA_W(32), .AVE_W(3), .MODE(0), .SIGNED(0), .ROUND(1)) u_blk (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(din_b), .data_en(en_b),
        .data_out(out_b), .out_valid(vld_b));

    multi_channel_average #(.CH_NUM(4), .DATA_W(32), .AVE_W(3), .MODE(0), .SIGNED(1), .ROUND(0)) u_sgn (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(din_s), .data_en(en_s),
        .data_out(out_s), .out_valid(vld_s));

    multi_channel_average #(.CH_NUM(4), .DATA_W(32), .AVE_W(2), .MODE(1), .SIGNED(0), .ROUND(1)) u_mov (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(din_m), .data_en(en_m),
        .data_out(out_m), .out_valid(vld_m));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; clr = 1'b0;
        din_b = '0; din_s = '0; din_m = '0;
        en_b = '0; en_s = '0; en_m = '0;

        #12;
        chk("rst_out_b", out_b[31:0], 32'd0);
        chk("rst_vld_all", {20'd0, vld_b, vld_s, vld_m}, 32'd0);
        rst_n = 1'b1;

        // Block, unsigned, rounding: 1..8 -> 5, 9..16 -> 13
        for (int i = 1; i <= 16; i++) begin
            din_b[31:0] = 32'(i);
            en_b = 4'b0001;
            tick();
            if (i == 8) chk("blk_novld_early", {28'd0, vld_b}, 32'd0);
            if (i == 9) begin
                chk("blk_avg1", out_b[31:0], 32'd5);
                chk("blk_vld1", {28'd0, vld_b}, 32'h1);
            end
            if (i == 10) begin
                chk("blk_vld_one_cycle", {28'd0, vld_b}, 32'd0);
                chk("blk_hold1", out_b[31:0], 32'd5);
            end
        end
        en_b = '0;
        tick();
        chk("blk_avg2", out_b[31:0], 32'd13);
        chk("blk_vld2", {28'd0, vld_b}, 32'h1);

        // Block, signed, truncate, gapped strobes on ch1
        for (int i = 0; i < 8; i++) begin
            din_s[63:32] = 32'hFFFF_FFFD;
            en_s = 4'b0010;
            tick();
            en_s = '0;
            tick();
        end
        chk("sgn_m3", out_s[63:32], 32'hFFFF_FFFD);
        chk("sgn_vld", {28'd0, vld_s}, 32'h2);
        for (int i = 0; i < 8; i++) begin
            din_s[63:32] = (i == 7) ? 32'd0 : 32'hFFFF_FFFF;
            en_s = 4'b0010;
            tick();
            en_s = '0;
            tick();
        end
        chk("sgn_floor", out_s[63:32], 32'hFFFF_FFFF);

        // Moving, N=4, ch2: 4,8,12,16,20 -> 10 then 14 back to back
        for (int i = 1; i <= 5; i++) begin
            din_m[95:64] = 32'(4 * i);
            en_m = 4'b0100;
            tick();
            if (i <= 4) chk("mov_novld", {28'd0, vld_m}, 32'd0);
        end
        chk("mov_avg1", out_m[95:64], 32'd10);
        chk("mov_vld1", {28'd0, vld_m}, 32'h4);
        en_m = '0;
        tick();
        chk("mov_avg2", out_m[95:64], 32'd14);
        chk("mov_vld2", {28'd0, vld_m}, 32'h4);
        tick();
        chk("mov_vld_end", {28'd0, vld_m}, 32'd0);

        // Independence: all channels together, then ch3 alone
        for (int i = 0; i < 8; i++) begin
            din_b = {32'd4, 32'd3, 32'd2, 32'd1};
            en_b = 4'b1111;
            tick();
        end
        en_b = '0;
        tick();
        chk("ind_ch0", out_b[31:0], 32'd1);
        chk("ind_ch1", out_b[63:32], 32'd2);
        chk("ind_ch2", out_b[95:64], 32'd3);
        chk("ind_ch3", out_b[127:96], 32'd4);
        chk("ind_vld4", {28'd0, vld_b}, 32'hF);
        for (int i = 0; i < 8; i++) begin
            din_b[127:96] = 32'd40;
            en_b = 4'b1000;
            tick();
        end
        en_b = '0;
        tick();
        chk("solo_ch3", out_b[127:96], 32'd40);
        chk("solo_vld", {28'd0, vld_b}, 32'h8);
        chk("solo_ch0_hold", out_b[31:0], 32'd1);
        chk("solo_ch2_hold", out_b[95:64], 32'd3);

        // clr after 5 of 8 samples, sample in the clr cycle is dropped
        din_b = '0;
        for (int i = 0; i < 5; i++) begin
            din_b[31:0] = 32'd50;
            en_b = 4'b0001;
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en_b = '0;
        chk("clr_hold", out_b[31:0], 32'd1);
        chk("clr_novld", {28'd0, vld_b}, 32'd0);
        tick();
        chk("clr_novld2", {28'd0, vld_b}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            din_b[31:0] = 32'd100;
            en_b = 4'b0001;
            tick();
        end
        // This edge delivers the 100 result and starts a new window with a 9.
        din_b[31:0] = 32'd9;
        tick();
        en_b = '0;
        chk("clr_after", out_b[31:0], 32'd100);
        chk("clr_after_vld", {28'd0, vld_b}, 32'h1);

        // Asynchronous reset mid-window, between clock edges, with valid high
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_b0", out_b[31:0], 32'd0);
        chk("arst_out_b3", out_b[127:96], 32'd0);
        chk("arst_out_m2", out_m[95:64], 32'd0);
        chk("arst_vld", {28'd0, vld_b}, 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din_b[31:0] = 32'd7;
            en_b = 4'b0001;
            tick();
            if (i == 0) chk("arst_vld_quiet", {28'd0, vld_b}, 32'd0);
        end
        en_b = '0;
        tick();
        chk("arst_window7", out_b[31:0], 32'd7);
        chk("arst_vld7", {28'd0, vld_b}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
